quet_12led: RTL
===============

# quet_12led

Scan driver for the 12-digit 7-segment display. It sits directly downstream of the mode/blink processing stage. Each slot it takes the 12 BCD digit values, the per-digit decimal-point mask `dc_12led` and the per-digit enable/blink mask `ena_12led`, and time-multiplexes them onto one shared segment bus plus 12 digit selects. A short all-off blanking interval at every digit change prevents ghosting.

## Interface
- `DIV`, default 4000: clock cycles per digit slot (50 MHz → 12.5 kHz per digit, ≈1.04 kHz frame). Must satisfy DIV ≥ BLANK+2.
- `BLANK`, default 50: cycles at the start of each slot during which all anodes are off. 0 disables blanking.
- `ckht`  in  1: system clock, single clock domain.
- `rst`  in  1: reset, synchronous, active-high.
- `so_12led`  in  48: BCD digit values; digit i = bits [4i+3:4i], digit 0 rightmost.
- `dc_12led`  in  12: decimal-point mask; bit i = 1 lights the dp of digit i.
- `ena_12led`  in  12: digit enable; bit i = 0 blanks digit i (used for blinking).
- `anode`  out  12: digit selects, active-low, one-hot-low or all-high.
- `sseg`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1: decimal point, active-low.

## Operation
- Slot counter `cnt` counts 0..DIV-1 and wraps. Digit index `idx` counts 0..11. `idx` increments when `cnt` = DIV-1; from 11 it wraps to 0.
- Phase FSM per slot, 2 states:
  - BLANK_ST: holds while `cnt` < BLANK.
  - SHOW_ST: holds while BLANK ≤ `cnt` ≤ DIV-1.
  - With BLANK = 0 the FSM is always in SHOW_ST.
- SHOW_ST with `ena_12led[idx]` = 1:
  - `anode` = all ones except bit `idx` = 0.
  - `sseg` = decode(`so_12led[4idx+3:4idx]`).
  - `dp` = ~`dc_12led[idx]`.
- SHOW_ST with `ena_12led[idx]` = 0: `anode` = 12'hFFF, `sseg` = 7'h7F, `dp` = 1.
- BLANK_ST: `anode` = 12'hFFF, `sseg` = 7'h7F, `dp` = 1.
- Decode table (active-low gfedcba):
  - 0→40, 1→79, 2→24, 3→30, 4→19
  - 5→12, 6→02, 7→78, 8→00, 9→10
  - A→3F (minus sign); B..F→7F (blank).
- Inputs are not latched per slot. They are sampled every cycle, so a change to data, dc or ena mid-slot appears on the outputs one cycle later.
- Never more than one anode low in any cycle.

## Timing
- All outputs are registered. Output at cycle t+1 reflects `cnt`, `idx` and inputs at cycle t: one-cycle latency.
- Reset (`rst` = 1 at a rising edge) forces:
  - `cnt` = 0, `idx` = 0, FSM = BLANK_ST (SHOW_ST if BLANK = 0).
  - `anode` = 12'hFFF, `sseg` = 7'h7F, `dp` = 1.
- After reset release, `cnt` starts counting at the first edge with `rst` = 0. With DIV = 8, BLANK = 2, digit 0 is first lit on the 3rd output cycle after release.
- Reset asserted mid-slot aborts the slot. Outputs go all-off on the next edge and the scan restarts at digit 0.
- Full frame = 12·DIV cycles. Every digit is lit for exactly DIV-BLANK cycles per frame, including across the 11→0 wrap.
- Width rules:
  - `cnt` width = clog2(DIV).
  - `idx` is 4 bits; values 12..15 are unreachable. If ever reached they are treated as blank, and `idx` returns to 0 at the next slot boundary.

## Test plan
Benches run with DIV = 8, BLANK = 2.
- Reset check: hold `rst` 3 cycles → `anode` = FFF, `sseg` = 7F, `dp` = 1 throughout; release → `anode` = FFE from the 3rd output cycle for 6 cycles, then FFF for 2 cycles, then FFD.
- Full frame: `so_12led` = 48'h0123_4567_89A0, all enables 1, dc = 0 → digit 0 shows 40 (0), digit 1 shows 3F (A/minus), digit 2 shows 10 (9) … digit 11 shows 40 (0); frame period 96 cycles; `idx` wraps 11→0 cleanly.
- Decimal points: dc = 12'h801 → `dp` = 0 only during the lit windows of digits 0 and 11.
- Blink mask: `ena_12led` = 12'hFF0 → during slots 0..3, `anode` = FFF and `sseg` = 7F; other digits unaffected.
- Mid-slot changes:
  - Change digit 5 value from 3 to 8 at `cnt` = 4 of slot 5 → `sseg` goes 30→00 exactly one cycle later.
  - Assert `rst` at `cnt` = 5 of slot 7 → all-off next cycle; scan restarts at digit 0.
- Invariant check across 10 frames with random inputs: `anode` is always one-hot-low or FFF; never two digits on.

Source files
------------

// File: rtl/quet_12led_if.sv
// Display bus between the mode/blink stage and the 12-digit scan driver.
// master feeds digit data and masks; slave drives anodes and segments.
interface quet_12led_if;
  logic [47:0] so_12led;
  logic [11:0] dc_12led;
  logic [11:0] ena_12led;
  logic [11:0] anode;
  logic [6:0]  sseg;
  logic        dp;

  modport master (
    output so_12led,
    output dc_12led,
    output ena_12led,
    input  anode,
    input  sseg,
    input  dp
  );

  modport slave (
    input  so_12led,
    input  dc_12led,
    input  ena_12led,
    output anode,
    output sseg,
    output dp
  );
endinterface

// File: rtl/quet_12led.sv
// 12-digit 7-segment scan driver with per-slot blanking.
// Outputs are registered and follow cnt/idx/inputs by one cycle.
module quet_12led #(
  parameter int DIV   = 4000,
  parameter int BLANK = 50
) (
  input  logic         ckht,
  input  logic         rst,
  quet_12led_if.slave  bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic {
    BLANK_ST,
    SHOW_ST
  } phase_e;

  // With no blanking the slot is shown from its very first cycle.
  localparam phase_e RST_ST = (BLANK == 0) ? SHOW_ST : BLANK_ST;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  phase_e        state_q, state_d;

  logic [11:0]   anode_q, anode_d;
  logic [6:0]    sseg_q, sseg_d;
  logic          dp_q, dp_d;

  logic [3:0]    dig;
  logic          dc_sel;
  logic          ena_sel;
  logic          idx_ok;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h3F;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Slot counter and digit index; idx 12..15 fold back to 0 at the boundary.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q >= 4'd11) ? 4'd0 : idx_q + 4'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter and index registers.
  always_ff @(posedge ckht) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Phase register: tracks whether the current cnt is in the blank window.
  always_ff @(posedge ckht) begin
    if (rst) begin
      state_q <= RST_ST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next phase derived from where the counter lands next cycle.
  always_comb begin
    state_d = state_q;
    if (int'(cnt_d) < BLANK) begin
      state_d = BLANK_ST;
    end else begin
      state_d = SHOW_ST;
    end
  end

  // Pick the current digit's nibble and mask bits with constant selects.
  always_comb begin
    dig     = 4'hF;
    dc_sel  = 1'b0;
    ena_sel = 1'b0;
    idx_ok  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (idx_q == 4'(i)) begin
        dig     = bus.so_12led[4*i +: 4];
        dc_sel  = bus.dc_12led[i];
        ena_sel = bus.ena_12led[i];
        idx_ok  = 1'b1;
      end
    end
  end

  // Output decode: light one anode only while showing an enabled digit.
  always_comb begin
    anode_d = 12'hFFF;
    sseg_d  = 7'h7F;
    dp_d    = 1'b1;
    if (state_q == SHOW_ST && idx_ok && ena_sel) begin
      anode_d = ~(12'd1 << idx_q);
      sseg_d  = seg_decode(dig);
      dp_d    = ~dc_sel;
    end
  end

  // Output registers; reset forces everything dark.
  always_ff @(posedge ckht) begin
    if (rst) begin
      anode_q <= 12'hFFF;
      sseg_q  <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      anode_q <= anode_d;
      sseg_q  <= sseg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.anode = anode_q;
  assign bus.sseg  = sseg_q;
  assign bus.dp    = dp_q;

endmodule
